// File: rtl/seq_mul_add.sv
// seq_mul_add: sequential shift-and-add multiply-accumulate.
// Computes result = q*b + r over WIDTH clock cycles, one multiplier bit per
// cycle (LSB first), using a valid/ready handshake on both sides.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set on q/b/r is valid
//   in_ready   block can accept operands (IDLE only)
//   q, b, r    unsigned multiplier, multiplicand, addend (WIDTH bits each)
//   out_valid  result/fits are valid (DONE only)
//   out_ready  consumer accepts the result
//   result     q*b + r (2*WIDTH bits); mirrors the accumulator at all times
//   fits       result < 2**WIDTH, captured on DONE entry
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | processing multiplier bit cnt
// DONE  | result held until out_ready

module seq_mul_add #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 fits
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [CW-1:0]        cnt;
    logic                 fits_reg;
    logic                 last_bit;
    logic                 accept;
    logic                 consume;

    // Partial product for the current multiplier bit and the running sum.
    always_comb begin
        partial  = '0;
        if (q_reg[cnt]) begin
            partial = {{WIDTH{1'b0}}, b_reg} << cnt;
        end
        acc_sum  = acc + partial;
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                consume   = out_ready;
                // Return to IDLE only; a new operand can be taken next cycle.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            fits_reg <= 1'b0;
        end else if (accept) begin
            q_reg <= q;
            b_reg <= b;
            acc   <= {{WIDTH{1'b0}}, r};
            cnt   <= '0;
        end else if (state == RUN) begin
            acc <= acc_sum;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                fits_reg <= (acc_sum[2*WIDTH-1:WIDTH] == '0);
            end
        end
    end

    assign result = acc;
    assign fits   = fits_reg;

    // consume is decoded for clarity of the handshake; state_nxt already uses it.
    logic unused_consume;
    assign unused_consume = consume;

endmodule

// File: tb/tb_seq_mul_add.sv
module tb_seq_mul_add;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   r;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               fits;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mul_add #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .b         (b),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .fits      (fits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks only the observable transaction timeline.
    // busy_left counts the edges still needed before the result appears.
    int  m_busy_left = 0;
    bit  m_done      = 0;
    bit  m_known     = 0;
    bit  m_started   = 0;
    int  m_q, m_b, m_r;
    int  m_res       = 0;
    bit  m_fits      = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy_left = 0;
            m_done      = 0;
            m_known     = 1;
            m_res       = 0;
            m_fits      = 0;
            m_started   = 1;
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_done  = 1;
                m_known = 1;
                m_res   = m_q * m_b + m_r;
                m_fits  = (m_res < (1 << WIDTH));
            end
        end else if (in_valid) begin
            m_q = q; m_b = b; m_r = r;
            m_busy_left = WIDTH;
            m_known     = 0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", in_ready, (!m_done && m_busy_left == 0));
            check("out_valid", out_valid, m_done);
            if (m_known) begin
                check("result", result, m_res);
                check("fits", fits, m_fits);
            end
        end
    end

    // One full transaction. exp_res < 0 skips the literal checks.
    task automatic run_op(input int qq, input int bb, input int rr, input int hold,
                          input bit hold_valid, input int exp_res, input int exp_fits);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        q = WIDTH'(qq); b = WIDTH'(bb); r = WIDTH'(rr);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        q = WIDTH'($urandom); b = WIDTH'($urandom); r = WIDTH'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, WIDTH);
        if (!out_valid) return;
        if (exp_res >= 0) begin
            check("lit_result", result, exp_res);
            check("lit_fits", fits, exp_fits);
            check("lit_model", m_res, exp_res);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = hold_valid;
            q = WIDTH'($urandom);
            @(negedge clk);
            if (exp_res >= 0) begin
                check("hold_valid", out_valid, 1);
                check("hold_ready", in_ready, 0);
                check("hold_result", result, exp_res);
            end
        end
        // in_valid stays as-is on the consuming edge; it must not be taken.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        q = '0; b = '0; r = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_fits", fits, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        run_op(3, 5, 2, 0, 0, 17, 0);
        run_op(0, 9, 7, 0, 0, 7, 1);
        run_op(2, 6, 3, 0, 0, 15, 1);
        run_op(15, 15, 15, 0, 0, 240, 0);
        run_op(5, 0, 4, 0, 0, 4, 1);
        run_op(2, 6, 3, 5, 1, 15, 1);

        // Reset during the second RUN cycle of 7*7+1.
        @(negedge clk);
        in_valid = 1'b1; q = 4'd7; b = 4'd7; r = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrst_result", result, 0);
        check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_out", out_valid, 0);
        end
        run_op(1, 1, 0, 0, 0, 1, 1);

        for (int qq = 0; qq < 16; qq++)
            for (int bb = 0; bb < 16; bb++)
                for (int rr = 0; rr < 16; rr++) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    run_op(qq, bb, rr, $urandom_range(0, 1), 1'($urandom_range(0, 1)), -1, 0);
                end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul_add.md
SEQ_MUL_ADD -- requirements
Module: seq_mul_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set on q/b/r is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port q, input, WIDTH bits: unsigned multiplier (quotient).
REQ-007 The block SHALL have port b, input, WIDTH bits: unsigned multiplicand (divisor).
REQ-008 The block SHALL have port r, input, WIDTH bits: unsigned addend (remainder).
REQ-009 The block SHALL have port out_valid, output, 1 bit: result and fits are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, 2*WIDTH bits: q*b + r, unsigned.
REQ-012 The block SHALL have port fits, output, 1 bit: high when result < 2**WIDTH.

Function
REQ-013 The block SHALL compute result = q*b + r exactly; max value (2**WIDTH-1)**2 + 2**WIDTH-1 < 2**(2*WIDTH), so no overflow bit exists.
REQ-014 The block SHALL implement an FSM with exactly three states: IDLE, RUN, DONE.
REQ-015 The block SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE; both are decoded from registered state.
REQ-016 Acceptance SHALL occur on an edge where in_valid & in_ready; at that edge the block registers q and b, loads accumulator = zero-extended r, clears the bit counter, and enters RUN.
REQ-017 The block SHALL ignore q/b/r changes after the acceptance edge, and in_valid while not in IDLE.
REQ-018 In RUN, each edge SHALL process one multiplier bit, LSB first: for counter i, add (b << i) to the accumulator iff q[i] = 1, then increment i.
REQ-019 At the edge processing i = WIDTH-1, the block SHALL enter DONE; out_valid is therefore first high exactly WIDTH cycles after the acceptance edge.
REQ-020 In DONE, result and fits SHALL hold stable until the edge where out_valid & out_ready, which returns the FSM to IDLE.
REQ-021 The block SHALL NOT accept a new operand in the same cycle a result is consumed; back-to-back throughput is one operation per WIDTH+2 cycles minimum.
REQ-022 result SHALL equal the accumulator register at all times; its value outside DONE is don't-care for consumers but deterministic.
REQ-023 fits SHALL be computed from the final accumulator (upper WIDTH bits all zero) and registered with the DONE entry.
REQ-024 The edge cases q = 0 or b = 0 SHALL still take the full WIDTH RUN cycles and yield result = r.

Reset
REQ-025 When rst = 1 at a clock edge, the block SHALL enter IDLE, clear the accumulator, counter and operand registers, and drive result = 0, fits = 0, out_valid = 0, in_ready = 1 after that edge.
REQ-026 rst SHALL take priority over every other input in any state, including mid-RUN and DONE; the in-flight operation is discarded with no output.
REQ-027 in_valid asserted in the same cycle as rst SHALL NOT be accepted.

Verification (WIDTH = 4)
REQ-028 Basic: q=3, b=5, r=2 accepted -> out_valid high exactly 4 cycles later, result=17, fits=0.
REQ-029 Zero/fits: q=0, b=9, r=7 -> result=7, fits=1 after 4 RUN cycles; q=2, b=6, r=3 -> result=15, fits=1.
REQ-030 Maximum: q=15, b=15, r=15 -> result=240, fits=0.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle with in_ready=1.
REQ-032 Reset mid-operation: rst pulse at the 2nd RUN cycle of q=7, b=7, r=1 -> out_valid never rises, result=0, in_ready=1; the next operation q=1, b=1, r=0 yields 1.
REQ-033 Exhaustive: all q, b, r in 0..15 against the reference model q*b+r, including fits, with random in_valid/out_ready gaps -> zero mismatches.
